// File: rtl/pipelined_cla_addsub_if.sv
// pipelined_cla_addsub_if: operand/result stream bundle for the pipelined CLA adder/subtractor.
interface pipelined_cla_addsub_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport master (
        output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport slave (
        input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/pipelined_cla_addsub.sv
// pipelined_cla_addsub: WIDTH-bit add/sub split into STAGES registered CLA segments with valid/ready flow control.
// Define CLA_PIPE_SAT_EN to clamp overflowing results to signed saturation in the final stage.
module pipelined_cla_addsub #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int GROUP  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipelined_cla_addsub_if.slave bus
);
    localparam int SEG  = WIDTH / STAGES;
    localparam int NGRP = SEG / GROUP;
    localparam logic [STAGES-1:0] ONES = '1;

    // Two-level lookahead over one segment; returns {carry into MSB, carry out, sum}.
    function automatic logic [SEG+1:0] cla_seg(input logic [SEG-1:0] a, input logic [SEG-1:0] b, input logic ci);
        logic [SEG-1:0] g, p, c;
        logic [NGRP:0]  gc;
        logic           gg, gp;
        g  = a & b;
        p  = a ^ b;
        c  = '0;
        gc = '0;
        gc[0] = ci;
        for (int j = 0; j < NGRP; j++) begin
            gg = 1'b0;
            gp = 1'b1;
            for (int i = 0; i < GROUP; i++) begin
                gg = g[j*GROUP+i] | (p[j*GROUP+i] & gg);
                gp = gp & p[j*GROUP+i];
            end
            gc[j+1] = gg | (gp & gc[j]);
        end
        for (int j = 0; j < NGRP; j++) begin
            c[j*GROUP] = gc[j];
            for (int i = 1; i < GROUP; i++)
                c[j*GROUP+i] = g[j*GROUP+i-1] | (p[j*GROUP+i-1] & c[j*GROUP+i-1]);
        end
        return {c[SEG-1], gc[NGRP], p ^ c};
    endfunction

    logic [STAGES-1:0] vld_q, v_in, rdy, c_q, c_in;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic [WIDTH-1:0]  a_in [STAGES];
    logic [WIDTH-1:0]  b_in [STAGES];
    logic [WIDTH-1:0]  s_in [STAGES];
    logic [WIDTH-1:0]  s_d [STAGES];
    logic [SEG+1:0]    r [STAGES];
    logic [WIDTH-1:0]  sum_d;
    logic              ovf_d, ovf_q;

    // Stage 0 takes the bus operands (B inverted, carry forced for subtract); later stages take the skewed registers.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign v_in[0] = bus.in_valid;
            assign a_in[0] = bus.in_a;
            assign b_in[0] = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign c_in[0] = bus.in_sub | bus.in_cin;
            assign s_in[0] = '0;
        end else begin : g_body
            assign v_in[k] = vld_q[k-1];
            assign a_in[k] = a_q[k-1];
            assign b_in[k] = b_q[k-1];
            assign c_in[k] = c_q[k-1];
            assign s_in[k] = s_q[k-1];
        end
        assign r[k]   = cla_seg(SEG'(a_in[k] >> (k*SEG)), SEG'(b_in[k] >> (k*SEG)), c_in[k]);
        assign s_d[k] = s_in[k] | (WIDTH'(r[k][SEG-1:0]) << (k*SEG));
    end

    assign ovf_d = r[STAGES-1][SEG+1] ^ r[STAGES-1][SEG];
`ifdef CLA_PIPE_SAT_EN
    assign sum_d = !ovf_d ? s_d[STAGES-1] :
                   s_d[STAGES-1][WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}} : {1'b1, {(WIDTH-1){1'b0}}};
`else
    assign sum_d = s_d[STAGES-1];
`endif

    // A stage may load when it is empty or every stage after it up to the output can move.
    always_comb begin
        rdy = '0;
        for (int k = 0; k < STAGES; k++)
            rdy[k] = bus.out_ready || ((vld_q >> k) != (ONES >> k));
    end

    // Advance every ready stage; a stalled stage keeps its beat, so the output holds under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            c_q   <= '0;
            ovf_q <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld_q[k] <= v_in[k];
                    a_q[k]   <= a_in[k];
                    b_q[k]   <= b_in[k];
                    c_q[k]   <= r[k][SEG];
                    s_q[k]   <= (k == STAGES-1) ? sum_d : s_d[k];
                end
            end
            if (rdy[STAGES-1])
                ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = rdy[0];
    assign bus.out_valid = vld_q[STAGES-1];
    assign bus.out_sum   = s_q[STAGES-1];
    assign bus.out_cout  = c_q[STAGES-1];
    assign bus.out_ovf   = ovf_q;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb_pipelined_cla_addsub: directed and randomised streaming checks of pipelined_cla_addsub against an arithmetic model.
module tb_pipelined_cla_addsub;
    localparam int WIDTH  = 32;
    localparam int STAGES = 2;
    localparam int GROUP  = 4;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    bit   rand_stall = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   n_out = 0;
    res_t exp_q[$];

    always #5 clk = ~clk;

    pipelined_cla_addsub_if #(.WIDTH(WIDTH)) bus ();

    pipelined_cla_addsub #(.WIDTH(WIDTH), .STAGES(STAGES), .GROUP(GROUP)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin, input logic sub);
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        res_t             res;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(sub ? 1'b1 : cin);
        res.sum  = full[WIDTH-1:0];
        res.cout = full[WIDTH];
        res.ovf  = (a[WIDTH-1] == bb[WIDTH-1]) && (res.sum[WIDTH-1] != a[WIDTH-1]);
`ifdef CLA_PIPE_SAT_EN
        if (res.ovf)
            res.sum = a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
        return res;
    endfunction

    function automatic logic [WIDTH-1:0] rnd();
        logic [63:0] w;
        w = {$urandom(), $urandom()};
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(WIDTH-1){1'b1}}};
            3:       return {1'b1, {(WIDTH-1){1'b0}}};
            default: return w[WIDTH-1:0];
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Caller is at posedge+2; holds the beat until accepted, returns at posedge+2 after the accepting edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin, input logic sub);
        int n;
        n = 0;
        bus.in_a = a;
        bus.in_b = b;
        bus.in_cin = cin;
        bus.in_sub = sub;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 200) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: got in_ready=0 for %0d cycles expected acceptance", n);
        end
        @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // Record the expected result of every accepted beat.
    always @(posedge clk)
        if (rst_n && bus.in_valid && bus.in_ready)
            exp_q.push_back(model(bus.in_a, bus.in_b, bus.in_cin, bus.in_sub));

    always @(negedge rst_n) exp_q.delete();

    always @(posedge clk) begin
        #1;
        if (rand_stall)
            bus.out_ready = ($urandom_range(0, 3) != 0);
    end

    // Compare every delivered result and confirm stalled outputs hold.
    res_t held;
    bit   stalled = 1'b0;
    always @(negedge clk) begin
        res_t cur, req;
        cur = {bus.out_sum, bus.out_cout, bus.out_ovf};
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                check("hold_valid", 64'(bus.out_valid), 64'd1);
                check("hold_data", 64'(cur), 64'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got %0h expected no output", cur);
                end else begin
                    req = exp_q.pop_front();
                    check("result", 64'(cur), 64'(req));
                end
                n_out++;
            end
            stalled = bus.out_valid && !bus.out_ready;
            held = cur;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1);
    end

    initial begin
        int e, base;
        bus.in_valid = 1'b0;
        bus.in_a = '0;
        bus.in_b = '0;
        bus.in_cin = 1'b0;
        bus.in_sub = 1'b0;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_sum", 64'(bus.out_sum), 64'd0);
        check("rst_out_cout", 64'(bus.out_cout), 64'd0);
        check("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #2;

        check("pin_seg_carry", 64'(model(32'h0000FFFF, 32'h1, 1'b0, 1'b0)), 64'({32'h00010000, 1'b0, 1'b0}));
        check("pin_sub_borrow", 64'(model(32'd5, 32'd7, 1'b1, 1'b1)), 64'({32'hFFFFFFFE, 1'b0, 1'b0}));
        check("pin_wrap_cout", 64'(model(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0)), 64'({32'h00000000, 1'b1, 1'b0}));
`ifdef CLA_PIPE_SAT_EN
        check("pin_sub_ovf", 64'(model(32'h80000000, 32'h1, 1'b0, 1'b1)), 64'({32'h80000000, 1'b1, 1'b1}));
        check("pin_add_ovf", 64'(model(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0)), 64'({32'h7FFFFFFF, 1'b0, 1'b1}));
`else
        check("pin_sub_ovf", 64'(model(32'h80000000, 32'h1, 1'b0, 1'b1)), 64'({32'h7FFFFFFF, 1'b1, 1'b1}));
        check("pin_add_ovf", 64'(model(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0)), 64'({32'h80000000, 1'b0, 1'b1}));
`endif

        send(32'h0000FFFF, 32'h1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        e = 1;
        while (!bus.out_valid && e < 20) begin
            @(posedge clk);
            #2;
            e++;
        end
        check("latency_edges", 64'(e), 64'(STAGES));
        check("latency_sum", 64'(bus.out_sum), 64'h00010000);
        drain();

        send(32'd5, 32'd7, 1'b1, 1'b1);
        send(32'h80000000, 32'h1, 1'b0, 1'b1);
        send(32'h7FFFFFFF, 32'h1, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 32'h0, 1'b1, 1'b0);
        send(32'h12345678, 32'h87654321, 1'b1, 1'b0);
        send(32'h00000000, 32'h00000001, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        drain();

        base = n_out;
        fork
            begin
                for (int i = 0; i < 8; i++)
                    send(32'(i) * 32'h11111111, 32'h0F0F0F0F ^ 32'(i), 1'(i >> 1), 1'(i));
                bus.in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                check("bp_in_ready", 64'(bus.in_ready), 64'd0);
                check("bp_out_valid", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b1;
            end
        join
        drain();
        check("bp_count", 64'(n_out - base), 64'd8);

        bus.out_ready = 1'b0;
        send(32'h1, 32'h2, 1'b0, 1'b0);
        send(32'h3, 32'h4, 1'b0, 1'b1);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(bus.out_valid), 64'd0);
        check("rst_async_sum", 64'(bus.out_sum), 64'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #2;
            check("rst_no_stale", 64'(bus.out_valid), 64'd0);
        end
        send(32'h0000FFFF, 32'h1, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        rand_stall = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                @(posedge clk);
                #2;
            end
            send(rnd(), rnd(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        bus.in_valid = 1'b0;
        rand_stall = 1'b0;
        bus.out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
